// File: rtl/pipe_stage_skid.sv
// Reusable pipeline-stage register with a valid/ready handshake and a one-entry skid buffer.
// It supports synchronous flush and provides saturating stall and bubble counters.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic                r_out_valid;
  logic                w_nxt_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   w_nxt_data;
  logic [CTRL_W-1:0]   r_out_ctrl;
  logic [CTRL_W-1:0]   w_nxt_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [DATA_W-1:0]   w_nxt_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CTRL_W-1:0]   w_nxt_skid_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_bubble_cnt;
  logic                w_in_ready;
  logic                w_acc;
  logic                w_rel;

  // flush -> in_ready is the only combinational path through the stage
  assign w_in_ready = (r_state != ST_FULL) & ~flush;
  assign w_acc      = in_valid & w_in_ready;
  assign w_rel      = r_out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state and next-payload selection
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_valid     = r_out_valid;
    w_nxt_data      = r_out_data;
    w_nxt_ctrl      = r_out_ctrl;
    w_nxt_skid_data = r_skid_data;
    w_nxt_skid_ctrl = r_skid_ctrl;

    if (flush && (r_state != ST_EMPTY)) begin
      w_nxt_state     = ST_EMPTY;
      w_nxt_valid     = 1'b0;
      w_nxt_data      = '0;
      w_nxt_ctrl      = CTRL_NOP;
      w_nxt_skid_data = '0;
      w_nxt_skid_ctrl = '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_nxt_state = ST_BUSY;
            w_nxt_valid = 1'b1;
            w_nxt_data  = in_data;
            w_nxt_ctrl  = in_ctrl;
          end
        end
        ST_BUSY: begin
          if (w_acc && w_rel) begin
            w_nxt_data = in_data;
            w_nxt_ctrl = in_ctrl;
          end else if (w_acc) begin
            // Main entry is stalled; park the new one behind it
            w_nxt_state     = ST_FULL;
            w_nxt_skid_data = in_data;
            w_nxt_skid_ctrl = in_ctrl;
          end else if (w_rel) begin
            w_nxt_state = ST_EMPTY;
            w_nxt_valid = 1'b0;
            w_nxt_ctrl  = CTRL_NOP;
          end
        end
        ST_FULL: begin
          if (w_rel) begin
            w_nxt_state = ST_BUSY;
            w_nxt_data  = r_skid_data;
            w_nxt_ctrl  = r_skid_ctrl;
          end
        end
        default: begin
          w_nxt_state = ST_EMPTY;
          w_nxt_valid = 1'b0;
          w_nxt_data  = '0;
          w_nxt_ctrl  = CTRL_NOP;
        end
      endcase
    end
  end

  // Payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= CTRL_NOP;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_out_valid <= w_nxt_valid;
      r_out_data  <= w_nxt_data;
      r_out_ctrl  <= w_nxt_ctrl;
      r_skid_data <= w_nxt_skid_data;
      r_skid_ctrl <= w_nxt_skid_ctrl;
    end
  end

  // Saturating performance counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!r_out_valid && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ctrl   = r_out_ctrl;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. It uses a default-width instance and a second instance
// with 4-bit counters, and both instances share the same stimulus.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [15:0] s_out_ctrl;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = 16'h8000 | d[15:0];
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);
    check_eq("rst_bubble", 64'(bubble_cnt), 64'd0);
    #10 rst = 1'b0;

    // Bubbles: idle input, one count per cycle
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq("bubble_cnt", 64'(bubble_cnt), 64'(k));
      check_eq("bubble_ctrl", 64'(out_ctrl), 64'd0);
      check_eq("bubble_valid", 64'(out_valid), 64'd0);
    end

    // Stream 1..8 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i));
      step();
      check_eq("stream_valid", 64'(out_valid), 64'd1);
      check_eq("stream_data", 64'(out_data), 64'(i));
      check_eq("stream_ctrl", 64'(out_ctrl), 64'(16'h8000 + 16'(i)));
      check_eq("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'h0);
    step();
    check_eq("drain_valid", 64'(out_valid), 64'd0);
    check_eq("drain_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("drain_data_hold", 64'(out_data), 64'd8);
    check_eq("stream_stall", 64'(stall_cnt), 64'd0);
    check_eq("stream_bubble", 64'(bubble_cnt), 64'd6);

    // Back-pressure: A then B, stage goes FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    check_eq("bp_a_data", 64'(out_data), 64'hA);
    check_eq("bp_a_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hB);
    step();
    check_eq("bp_full_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_full_data", 64'(out_data), 64'hA);
    check_eq("bp_full_ctrl", 64'(out_ctrl), 64'h800A);
    drive(1'b0, 32'h0);
    step();
    check_eq("bp_hold_data", 64'(out_data), 64'hA);
    check_eq("bp_hold_stall", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    step();
    check_eq("bp_b_valid", 64'(out_valid), 64'd1);
    check_eq("bp_b_data", 64'(out_data), 64'hB);
    check_eq("bp_b_ctrl", 64'(out_ctrl), 64'h800B);
    check_eq("bp_b_in_ready", 64'(in_ready), 64'd1);
    step();
    check_eq("bp_empty_valid", 64'(out_valid), 64'd0);
    check_eq("bp_stall_after", 64'(stall_cnt), 64'd2);

    // Flush while FULL with C presented
    out_ready = 1'b0;
    drive(1'b1, 32'h11);
    step();
    drive(1'b1, 32'h12);
    step();
    check_eq("fl_full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hC);
    flush = 1'b1;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check_eq("fl_valid", 64'(out_valid), 64'd0);
    check_eq("fl_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("fl_data", 64'(out_data), 64'd0);
    check_eq("fl_stall", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("fl_no_c_valid", 64'(out_valid), 64'd0);
      check_eq("fl_no_c_data", 64'(out_data), 64'd0);
    end

    // Flush while EMPTY only drops in_ready
    flush = 1'b1;
    #1;
    check_eq("fl_empty_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b0;
    #1;
    check_eq("fl_empty_in_ready_back", 64'(in_ready), 64'd1);

    // Saturation: 20 stalled cycles
    out_ready = 1'b0;
    drive(1'b1, 32'h55);
    step();
    drive(1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check_eq("sat_10", 64'(s_stall_cnt), 64'd14);
      if (i == 11) check_eq("sat_11", 64'(s_stall_cnt), 64'd15);
    end
    check_eq("sat_end", 64'(s_stall_cnt), 64'd15);
    check_eq("wide_stall_end", 64'(stall_cnt), 64'd24);
    check_eq("sat_hold_data", 64'(out_data), 64'h55);

    // Async reset mid-cycle while BUSY
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_data", 64'(out_data), 64'd0);
    check_eq("arst_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("arst_stall", 64'(stall_cnt), 64'd0);
    check_eq("arst_bubble", 64'(bubble_cnt), 64'd0);
    check_eq("arst_sat_stall", 64'(s_stall_cnt), 64'd0);
    #2 rst = 1'b0;
    step();
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    check_eq("post_rst_bubble", 64'(bubble_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
